cmd_sequencer: RTL and testbench



---
 rtl/cmd_pkg.sv | 26 ++
 rtl/cmd_fifo.sv | 57 +++++
 rtl/cmd_sequencer.sv | 129 ++++++++++++
 tb/tb_cmd_sequencer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pkg.sv
// Command byte definitions, sequencer state encoding and the command whitelist
// shared by cmd_sequencer and its bench.
package cmd_pkg;

  localparam logic [7:0] CMD_EAT   = 8'h65;
  localparam logic [7:0] CMD_SLEEP = 8'h73;
  localparam logic [7:0] CMD_PLAY  = 8'h70;
  localparam logic [7:0] CMD_CLEAN = 8'h63;
  localparam logic [7:0] CMD_HEAL  = 8'h68;
  localparam logic [7:0] CMD_REST  = 8'h7A;
  localparam logic [7:0] CMD_NONE  = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_t;

  function automatic logic is_cmd(input logic [7:0] b);
    case (b)
      CMD_EAT, CMD_SLEEP, CMD_PLAY, CMD_CLEAN, CMD_HEAL, CMD_REST: is_cmd = 1'b1;
      default: is_cmd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO for pending commands; DEPTH must be a power of two so the
// pointers wrap naturally. Simultaneous push and pop are honoured even when full.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign level = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    count_d  = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/cmd_sequencer.sv
// Filters UART bytes against the command whitelist, queues them and presents each
// for HOLD_CYCLES followed by GAP_CYCLES of 0x00. CMD_CASE_FOLD_EN folds A-Z to a-z.
module cmd_sequencer
  import cmd_pkg::*;
#(
  parameter int HOLD_CYCLES = 1000,
  parameter int GAP_CYCLES  = 16,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [7:0]                     rx_data,
  input  logic                           rx_valid,
  output logic [7:0]                     cmd,
  output logic                           busy,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_level,
  output logic [7:0]                     drop_count
);

  localparam int LVL_W   = $clog2(QUEUE_DEPTH) + 1;
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       drop_q, drop_d;
  logic             busy_q, busy_d;
  logic [7:0]       rx_byte, head;
  logic             push, pop, full, empty, push_ok;
  logic [LVL_W-1:0] level, level_nxt;

  always_comb begin
    rx_byte = rx_data;
`ifdef CMD_CASE_FOLD_EN
    if (rx_data >= 8'h41 && rx_data <= 8'h5A) rx_byte = rx_data + 8'h20;
`endif
  end

  assign push = rx_valid && is_cmd(rx_byte);

  cmd_fifo #(.DEPTH(QUEUE_DEPTH), .WIDTH(8)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (rx_byte),
    .pop     (pop),
    .rdata   (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_d = CMD_NONE;
        if (!empty) begin
          pop     = 1'b1;
          cmd_d   = head;
          cnt_d   = HOLD_LD;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else begin
          cmd_d   = CMD_NONE;
          cnt_d   = GAP_LD;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else if (!empty) begin
          // Chain straight into the next command without passing through IDLE.
          pop     = 1'b1;
          cmd_d   = head;
          cnt_d   = HOLD_LD;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        cmd_d   = CMD_NONE;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // busy is registered, so it is derived from next-cycle state and FIFO occupancy.
  always_comb begin
    push_ok   = push && (!full || pop);
    level_nxt = level + LVL_W'(push_ok) - LVL_W'(pop);
    busy_d    = (state_d != ST_IDLE) || (level_nxt != '0);
    drop_d    = drop_q;
    if (push && full && !pop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= CMD_NONE;
      drop_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      drop_q  <= drop_d;
      busy_q  <= busy_d;
    end
  end

  assign cmd         = cmd_q;
  assign busy        = busy_q;
  assign drop_count  = drop_q;
  assign queue_level = level;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer with HOLD_CYCLES=4, GAP_CYCLES=2, QUEUE_DEPTH=4.
module tb_cmd_sequencer;

  localparam int H = 4;
  localparam int G = 2;
  localparam int D = 4;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic [7:0]           rx_data = 8'h00;
  logic                 rx_valid = 1'b0;
  logic [7:0]           cmd;
  logic                 busy;
  logic [$clog2(D):0]   queue_level;
  logic [7:0]           drop_count;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  cmd_sequencer #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .QUEUE_DEPTH(D)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .cmd         (cmd),
    .busy        (busy),
    .queue_level (queue_level),
    .drop_count  (drop_count)
  );

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    total++; if (cmd !== 8'h00) $display("FAIL reset_cmd got %h want 00", cmd); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
    total++; if (queue_level !== 3'd0) $display("FAIL reset_level got %0d want 0", queue_level); else pass_cnt++;
    total++; if (drop_count !== 8'd0) $display("FAIL reset_drop got %0d want 0", drop_count); else pass_cnt++;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    logic [7:0] exp;
    rx_data = 8'h65; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    total++; if (queue_level !== 3'd1) $display("FAIL single_level got %0d want 1", queue_level); else pass_cnt++;
    total++; if (cmd !== 8'h00) $display("FAIL single_cmd0 got %h want 00", cmd); else pass_cnt++;
    total++; if (busy !== 1'b1) $display("FAIL single_busy0 got %b want 1", busy); else pass_cnt++;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp = (t <= H) ? 8'h65 : 8'h00;
      total++; if (cmd !== exp) $display("FAIL single_cmd t=%0d got %h want %h", t, cmd, exp); else pass_cnt++;
      if (t == 6) begin
        total++; if (busy !== 1'b1) $display("FAIL single_busy_gap got %b want 1", busy); else pass_cnt++;
      end
    end
    total++; if (busy !== 1'b0) $display("FAIL single_busy_end got %b want 0", busy); else pass_cnt++;
    total++; if (drop_count !== 8'd0) $display("FAIL single_drop got %0d want 0", drop_count); else pass_cnt++;
  endtask

  task automatic test_filter();
    logic [7:0] bytes [4];
    logic [7:0] exp;
    bytes[0] = 8'h41; bytes[1] = 8'h0D; bytes[2] = 8'h00; bytes[3] = 8'h7A;
    for (int i = 0; i < 4; i++) begin
      rx_data = bytes[i]; rx_valid = 1'b1;
      tick();
      if (i < 3) begin
        total++; if (queue_level !== 3'd0) $display("FAIL filter_level i=%0d got %0d want 0", i, queue_level); else pass_cnt++;
      end
    end
    rx_valid = 1'b0;
    total++; if (queue_level !== 3'd1) $display("FAIL filter_level_z got %0d want 1", queue_level); else pass_cnt++;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp = (t <= H) ? 8'h7A : 8'h00;
      total++; if (cmd !== exp) $display("FAIL filter_cmd t=%0d got %h want %h", t, cmd, exp); else pass_cnt++;
    end
    total++; if (busy !== 1'b0) $display("FAIL filter_busy got %b want 0", busy); else pass_cnt++;
    total++; if (drop_count !== 8'd0) $display("FAIL filter_drop got %0d want 0", drop_count); else pass_cnt++;
  endtask

  task automatic test_case_fold();
    logic [$clog2(D):0] exp_lvl;
`ifdef CMD_CASE_FOLD_EN
    exp_lvl = 1;
`else
    exp_lvl = 0;
`endif
    rx_data = 8'h45; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    total++; if (queue_level !== exp_lvl) $display("FAIL fold_level got %0d want %0d", queue_level, exp_lvl); else pass_cnt++;
    tick();
    total++; if (cmd !== ((exp_lvl != 0) ? 8'h65 : 8'h00)) $display("FAIL fold_cmd got %h", cmd); else pass_cnt++;
    repeat (7) tick();
    total++; if (busy !== 1'b0) $display("FAIL fold_busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_overflow();
    logic [7:0] in_b [6];
    logic [7:0] exp_q [5];
    logic [7:0] trace [32];
    logic [7:0] exp;
    in_b[0] = 8'h65; in_b[1] = 8'h73; in_b[2] = 8'h70;
    in_b[3] = 8'h63; in_b[4] = 8'h68; in_b[5] = 8'h7A;
    // First pops at once, next four fill the FIFO, sixth arrives while full during HOLD.
    exp_q[0] = 8'h65; exp_q[1] = 8'h73; exp_q[2] = 8'h70; exp_q[3] = 8'h63; exp_q[4] = 8'h68;
    for (int t = 0; t < 6; t++) begin
      rx_data = in_b[t]; rx_valid = 1'b1;
      tick();
      trace[t] = cmd;
    end
    rx_valid = 1'b0;
    total++; if (queue_level !== 3'd4) $display("FAIL ovf_level got %0d want 4", queue_level); else pass_cnt++;
    total++; if (drop_count !== 8'd1) $display("FAIL ovf_drop got %0d want 1", drop_count); else pass_cnt++;
    for (int t = 6; t < 32; t++) begin
      tick();
      trace[t] = cmd;
      if (t == 30) begin
        total++; if (busy !== 1'b1) $display("FAIL ovf_busy_gap got %b want 1", busy); else pass_cnt++;
      end
    end
    total++; if (busy !== 1'b0) $display("FAIL ovf_busy_end got %b want 0", busy); else pass_cnt++;
    for (int t = 0; t < 32; t++) begin
      exp = (t >= 1 && ((t-1) % (H+G)) < H && ((t-1) / (H+G)) < 5) ? exp_q[(t-1)/(H+G)] : 8'h00;
      total++; if (trace[t] !== exp) $display("FAIL ovf_cmd t=%0d got %h want %h", t, trace[t], exp); else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] in_b [3];
    logic [7:0] trace [20];
    logic [7:0] exp;
    in_b[0] = 8'h70; in_b[1] = 8'h63; in_b[2] = 8'h68;
    for (int t = 0; t < 20; t++) begin
      if (t < 3) begin rx_data = in_b[t]; rx_valid = 1'b1; end
      else rx_valid = 1'b0;
      tick();
      trace[t] = cmd;
      if (t == 18) begin
        total++; if (busy !== 1'b1) $display("FAIL b2b_busy_gap got %b want 1", busy); else pass_cnt++;
      end
    end
    total++; if (busy !== 1'b0) $display("FAIL b2b_busy_end got %b want 0", busy); else pass_cnt++;
    for (int t = 0; t < 20; t++) begin
      exp = (t >= 1 && ((t-1) % (H+G)) < H && ((t-1) / (H+G)) < 3) ? in_b[(t-1)/(H+G)] : 8'h00;
      total++; if (trace[t] !== exp) $display("FAIL b2b_cmd t=%0d got %h want %h", t, trace[t], exp); else pass_cnt++;
    end
  endtask

  task automatic test_saturate();
    int n;
    rx_data = 8'h73; rx_valid = 1'b1;
    repeat (400) tick();
    rx_valid = 1'b0;
    total++; if (drop_count !== 8'd255) $display("FAIL sat_drop got %0d want 255", drop_count); else pass_cnt++;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    total++; if (busy !== 1'b0) $display("FAIL sat_drain busy got %b want 0 after %0d cycles", busy, n); else pass_cnt++;
    total++; if (drop_count !== 8'd255) $display("FAIL sat_hold got %0d want 255", drop_count); else pass_cnt++;
  endtask

  task automatic test_reset_mid_hold();
    logic [7:0] exp;
    rx_data = 8'h65; rx_valid = 1'b1; tick();
    rx_data = 8'h73; tick();
    rx_data = 8'h70; tick();
    rx_valid = 1'b0;
    total++; if (cmd !== 8'h65) $display("FAIL rst_pre_cmd got %h want 65", cmd); else pass_cnt++;
    total++; if (queue_level !== 3'd2) $display("FAIL rst_pre_level got %0d want 2", queue_level); else pass_cnt++;
    #2 reset_n = 1'b0;
    #1;
    total++; if (cmd !== 8'h00) $display("FAIL rst_cmd got %h want 00", cmd); else pass_cnt++;
    total++; if (queue_level !== 3'd0) $display("FAIL rst_level got %0d want 0", queue_level); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else pass_cnt++;
    total++; if (drop_count !== 8'd0) $display("FAIL rst_drop got %0d want 0", drop_count); else pass_cnt++;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    total++; if (cmd !== 8'h00) $display("FAIL rst_idle_cmd got %h want 00", cmd); else pass_cnt++;
    rx_data = 8'h73; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      tick();
      exp = (t <= H) ? 8'h73 : 8'h00;
      total++; if (cmd !== exp) $display("FAIL rst_after_cmd t=%0d got %h want %h", t, cmd, exp); else pass_cnt++;
    end
    total++; if (busy !== 1'b0) $display("FAIL rst_after_busy got %b want 0", busy); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_filter();
    test_case_fold();
    test_overflow();
    test_back_to_back();
    test_saturate();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
